// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared FSM state, slot record and vote-width helper for the k-NN classifier
package knn_pkg;

  localparam int MAX_W      = 32;
  localparam int MAX_TYPE_W = 8;

  typedef enum logic [1:0] {
    COLLECT,
    COUNT,
    SELECT,
    RESULT
  } state_t;

  // Fields are sized for the widest supported build; narrower builds zero-extend.
  typedef struct packed {
    logic                  valid;
    logic [MAX_W-1:0]      distance;
    logic [MAX_TYPE_W-1:0] cls;
  } slot_t;

  function automatic int vote_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_topk_buffer.sv
// rtl/knn_topk_buffer.sv - K-entry ascending-distance buffer with single-cycle stable insertion
module knn_topk_buffer
  import knn_pkg::*;
#(
  parameter int W      = 16,
  parameter int TYPE_W = 2,
  parameter int K      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              insert,
  input  logic [W-1:0]      in_distance,
  input  logic [TYPE_W-1:0] in_type,
  output slot_t             slots [K]
);

  slot_t          fresh;
  slot_t          nxt [K];
  logic [K-1:0]   lt;

  always_comb begin
    fresh          = '0;
    fresh.valid    = 1'b1;
    fresh.distance = MAX_W'(in_distance);
    fresh.cls      = MAX_TYPE_W'(in_type);
  end

  // Strict less-than puts a new sample behind equal distances; with every slot
  // full and no lt set, the sample simply falls off the end.
  for (genvar i = 0; i < K; i++) begin : g_slot
    assign lt[i] = !slots[i].valid || (fresh.distance < slots[i].distance);
    if (i == 0) begin : g_head
      assign nxt[i] = lt[i] ? fresh : slots[i];
    end else begin : g_tail
      assign nxt[i] = !lt[i] ? slots[i] : (lt[i-1] ? slots[i-1] : fresh);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) slots[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < K; i++) slots[i] <= '0;
    end else if (insert) begin
      for (int i = 0; i < K; i++) slots[i] <= nxt[i];
    end
  end

endmodule

// File: rtl/knn_topk_classifier.sv
// rtl/knn_topk_classifier.sv - streaming k-nearest-neighbour majority vote classifier
// Optional KNN_TIE_NEAREST_EN: vote ties go to the class owning the nearest slot.
module knn_topk_classifier
  import knn_pkg::*;
#(
  parameter int W      = 16,
  parameter int TYPE_W = 2,
  parameter int K      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_distance,
  input  logic [TYPE_W-1:0]    in_type,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TYPE_W-1:0]    out_type,
  output logic [vote_w(K)-1:0] out_votes
);

  localparam int NUM_TYPES = 1 << TYPE_W;
  localparam int VW        = vote_w(K);
  localparam int SW        = (K > 1) ? $clog2(K) : 1;

  state_t              state, state_nxt;
  logic                armed;
  logic [SW-1:0]       slot_idx;
  logic [TYPE_W-1:0]   cls_idx;
  logic [VW-1:0]       counts [NUM_TYPES];
  slot_t               slots [K];
  slot_t               cur;
  logic [TYPE_W-1:0]   cur_cls;
  logic                unused_cur_bits;
  logic                accept, clear, slot_done, cls_done, take;
`ifdef KNN_TIE_NEAREST_EN
  logic [SW-1:0]       near [NUM_TYPES];
  logic [SW-1:0]       best_near;
`endif

  // armed keeps in_ready low until the first edge after reset release.
  assign in_ready  = armed && (state == COLLECT);
  assign accept    = in_valid && in_ready;
  assign clear     = out_valid && out_ready;
  assign cur       = slots[slot_idx];
  assign cur_cls   = cur.cls[TYPE_W-1:0];
  assign unused_cur_bits = ^cur;
  assign slot_done = (slot_idx == SW'(K - 1));
  assign cls_done  = (cls_idx == {TYPE_W{1'b1}});

  knn_topk_buffer #(
    .W      (W),
    .TYPE_W (TYPE_W),
    .K      (K)
  ) u_buffer (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .insert      (accept),
    .in_distance (in_distance),
    .in_type     (in_type),
    .slots       (slots)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && in_last) state_nxt = COUNT;
      COUNT:   if (slot_done)         state_nxt = SELECT;
      SELECT:  if (cls_done)          state_nxt = RESULT;
      RESULT:  if (out_ready)         state_nxt = COLLECT;
      default:                        state_nxt = COLLECT;
    endcase
  end

  // Class 0 always seeds the scan; later classes must strictly beat it.
  always_comb begin
    take = (cls_idx == '0) || (counts[cls_idx] > out_votes);
`ifdef KNN_TIE_NEAREST_EN
    if ((counts[cls_idx] == out_votes) && (counts[cls_idx] != '0) &&
        (near[cls_idx] < best_near))
      take = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed     <= 1'b0;
      slot_idx  <= '0;
      cls_idx   <= '0;
      out_valid <= 1'b0;
      out_type  <= '0;
      out_votes <= '0;
      for (int c = 0; c < NUM_TYPES; c++) counts[c] <= '0;
`ifdef KNN_TIE_NEAREST_EN
      for (int c = 0; c < NUM_TYPES; c++) near[c] <= '0;
      best_near <= '0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        COUNT: begin
          if (cur.valid) begin
            counts[cur_cls] <= counts[cur_cls] + VW'(1);
`ifdef KNN_TIE_NEAREST_EN
            // Slots are ascending, so the first hit per class is its nearest.
            if (counts[cur_cls] == '0) near[cur_cls] <= slot_idx;
`endif
          end
          slot_idx <= slot_done ? '0 : slot_idx + SW'(1);
        end
        SELECT: begin
          if (take) begin
            out_type  <= cls_idx;
            out_votes <= counts[cls_idx];
`ifdef KNN_TIE_NEAREST_EN
            best_near <= near[cls_idx];
`endif
          end
          cls_idx <= cls_idx + TYPE_W'(1);
          if (cls_done) out_valid <= 1'b1;
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            for (int c = 0; c < NUM_TYPES; c++) counts[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_topk_classifier.sv
// tb/tb_knn_topk_classifier.sv - directed table-driven bench for knn_topk_classifier (K=3, 4 classes)
module tb_knn_topk_classifier;

`ifdef KNN_TIE_NEAREST_EN
  localparam bit TIE = 1'b1;
`else
  localparam bit TIE = 1'b0;
`endif
  localparam int LAT = 7;
  localparam int NB  = 33;
  localparam int NV  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_distance = '0;
  logic [1:0]  in_type = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_type;
  logic [1:0]  out_votes;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  t;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0] exp_type;
    logic [1:0] exp_votes;
  } vec_t;

  beat_t beats [NB];
  vec_t  vecs  [NV];

  knn_topk_classifier #(.W(16), .TYPE_W(2), .K(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_distance (in_distance),
    .in_type     (in_type),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_type    (out_type),
    .out_votes   (out_votes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] t, input logic last);
    int g = 0;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_distance = d; in_type = t; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ack_out_valid", 32'(out_valid), 32'd0);
    check("ack_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input int lat, input logic [1:0] et, input logic [1:0] ev);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_type"}, 32'(out_type), 32'(et));
    check({tag, "_votes"}, 32'(out_votes), 32'(ev));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int bi;

    beats = '{
      '{16'd40, 2'd1, 1'b0}, '{16'd10, 2'd2, 1'b0}, '{16'd30, 2'd1, 1'b0}, '{16'd20, 2'd2, 1'b1},
      '{16'd5,  2'd3, 1'b1},
      '{16'd10, 2'd1, 1'b0}, '{16'd20, 2'd2, 1'b1},
      '{16'd10, 2'd2, 1'b0}, '{16'd20, 2'd1, 1'b1},
      '{16'd10, 2'd1, 1'b0}, '{16'd20, 2'd3, 1'b0}, '{16'd30, 2'd1, 1'b0}, '{16'd30, 2'd0, 1'b0},
      '{16'd30, 2'd3, 1'b1},
      '{16'd15, 2'd2, 1'b0}, '{16'd15, 2'd2, 1'b0}, '{16'd15, 2'd1, 1'b0}, '{16'd15, 2'd1, 1'b1},
      '{16'd90, 2'd0, 1'b0}, '{16'd80, 2'd0, 1'b0}, '{16'd70, 2'd1, 1'b0}, '{16'd60, 2'd2, 1'b0},
      '{16'd50, 2'd2, 1'b0}, '{16'd40, 2'd3, 1'b1},
      '{16'd1,  2'd3, 1'b0}, '{16'd2,  2'd3, 1'b0}, '{16'd3,  2'd3, 1'b0}, '{16'd4,  2'd3, 1'b1},
      '{16'd30, 2'd3, 1'b0}, '{16'd20, 2'd2, 1'b0}, '{16'd10, 2'd1, 1'b1},
      '{16'd10, 2'd3, 1'b0}, '{16'd20, 2'd0, 1'b1}
    };
    vecs = '{
      '{2'd2, 2'd2},
      '{2'd3, 2'd1},
      '{2'd1, 2'd1},
      '{(TIE ? 2'd2 : 2'd1), 2'd1},
      '{2'd1, 2'd2},
      '{2'd2, 2'd2},
      '{2'd2, 2'd2},
      '{2'd3, 2'd3},
      '{2'd1, 2'd1},
      '{(TIE ? 2'd3 : 2'd0), 2'd1}
    };

    // Reset values, then in_ready rises only on the first edge after release.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_type", 32'(out_type), 32'd0);
    check("rst_out_votes", 32'(out_votes), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("release_in_ready_pre_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    bi = 0;
    for (int v = 0; v < NV; v++) begin
      logic done;
      done = 1'b0;
      while (!done && bi < NB) begin
        send(beats[bi].d, beats[bi].t, beats[bi].last);
        done = beats[bi].last;
        bi++;
      end
      wait_result(lat);
      check_result($sformatf("vec%0d", v), lat, vecs[v].exp_type, vecs[v].exp_votes);
      ack();
    end

    // Back-pressured result: stable outputs, in_ready low, in_valid ignored.
    send(16'd40, 2'd1, 1'b0);
    send(16'd10, 2'd2, 1'b0);
    send(16'd30, 2'd1, 1'b0);
    send(16'd20, 2'd2, 1'b1);
    wait_result(lat);
    check_result("hold", lat, 2'd2, 2'd2);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_distance = 16'd1; in_type = 2'd0; in_last = 1'b1;
      @(posedge clk); #1;
      check($sformatf("hold%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("hold%0d_type", c), 32'(out_type), 32'd2);
      check($sformatf("hold%0d_votes", c), 32'(out_votes), 32'd2);
    end
    in_valid = 1'b0; in_last = 1'b0;
    ack();
    send(16'd5, 2'd3, 1'b1);
    wait_result(lat);
    check_result("after_hold", lat, 2'd3, 2'd1);
    ack();

    // Reset pulse in COUNT discards the partial frame.
    send(16'd10, 2'd2, 1'b0);
    send(16'd20, 2'd2, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_type", 32'(out_type), 32'd0);
    check("midrst_out_votes", 32'(out_votes), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst_release_pre_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    send(16'd7, 2'd0, 1'b1);
    wait_result(lat);
    check_result("after_rst", lat, 2'd0, 2'd1);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_topk_classifier.md
KNN_TOPK_CLASSIFIER -- requirements
Module: knn_topk_classifier

Interface
REQ-001 SHALL have parameter W, default 16: distance width in bits.
REQ-002 SHALL have parameter TYPE_W, default 2: class label width; NUM_TYPES = 1<<TYPE_W.
REQ-003 SHALL have parameter K, default 5: neighbours kept, 1..15.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: sample beat valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample beat.
REQ-008 SHALL have port in_distance, input, W: sample distance to the query.
REQ-009 SHALL have port in_type, input, TYPE_W: sample class.
REQ-010 SHALL have port in_last, input, 1: final sample of the frame.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port out_type, output, TYPE_W: inferred class.
REQ-014 SHALL have port out_votes, output, $clog2(K+1): vote count of the winning class.

Function
REQ-015 SHALL implement FSM states COLLECT, COUNT, SELECT and RESULT; reset enters COLLECT with all K slots empty.
REQ-016 SHALL drive in_ready=1 only in COLLECT; a beat is accepted when in_valid and in_ready are both 1.
REQ-017 SHALL keep K slots sorted ascending by distance; an accepted beat is inserted in one cycle and the worst entry is shifted out when all slots are full.
REQ-018 SHALL place a new sample after existing entries of equal distance (stable ordering); when all slots are full, a distance >= the worst kept distance SHALL be discarded.
REQ-019 SHALL move to COUNT on an accepted beat with in_last=1, after inserting that beat.
REQ-020 COUNT SHALL take K cycles, one slot per cycle, incrementing the per-class counter of each occupied slot; empty slots SHALL NOT be counted.
REQ-021 SELECT SHALL take NUM_TYPES cycles, scanning classes 0..NUM_TYPES-1 and keeping the maximum count; without the tie macro, ties SHALL go to the lowest class index.
REQ-022 SHALL raise out_valid exactly K+NUM_TYPES cycles after the last-beat handshake edge, holding out_type and out_votes stable until out_ready.
REQ-023 On out_valid and out_ready both 1, SHALL clear the slots and counters, drop out_valid, and return to COLLECT on the next cycle.
REQ-024 SHALL ignore in_valid outside COLLECT; no sample SHALL be lost or altered.
REQ-025 out_votes SHALL be at most the number of occupied slots, which is min(K, accepted beats).

Reset
REQ-026 On reset (rst=0) SHALL asynchronously force in_ready=0, out_valid=0, out_type=0 and out_votes=0, empty all slots, and clear all counters.
REQ-027 in_ready SHALL go to 1 on the first clk edge after rst deasserts; reset in any state, including mid-frame, SHALL discard the partial frame.

Configuration
REQ-028 SHALL support macro KNN_TIE_NEAREST_EN.
REQ-029 When KNN_TIE_NEAREST_EN is defined, a SELECT tie SHALL be won by the tied class owning the nearest slot; the slot minimum index is recorded per class during COUNT.
REQ-030 When KNN_TIE_NEAREST_EN is undefined, ties SHALL go to the lowest class index, with no extra per-class registers.

Structure
REQ-031 SHALL use a shared package knn_pkg holding the FSM state enum, the slot struct {valid, distance, type}, and the helper function for vote-count width.
REQ-032 The sorted insertion array SHALL be the sub-module knn_topk_buffer, parametrised by W, TYPE_W and K, with clear and insert ports.

Verification
REQ-033 With K=3, beats (d,t) = (40,1), (10,2), (30,1), (20,2) and last: SHALL give out_type=2, out_votes=2 (kept 10/2, 20/2, 30/1), with out_valid 7 cycles after the last edge.
REQ-034 With a single beat (5,3) and last: SHALL give out_type=3, out_votes=1, with empty slots not counted.
REQ-035 With beats (10,1), (20,2) and last, K=3: without the macro SHALL give out_type=1; with KNN_TIE_NEAREST_EN and beats (10,2), (20,1) SHALL give out_type=2.
REQ-036 With slots full at 10, 20, 30 and a new beat (30,0): SHALL discard the beat; with (30,3) and last, out_type SHALL reflect the unchanged slots.
REQ-037 Holding out_ready=0 for 5 cycles SHALL keep the result stable and in_ready=0; in_valid pulses during that time SHALL have no effect; after out_ready, the next frame SHALL start from empty.
REQ-038 Pulsing rst=0 during COUNT SHALL give out_valid=0 immediately and in_ready=1 one edge after release; a fresh frame (7,0) with last SHALL give out_type=0.
